pwm_ramp_ctrl: RTL and testbench



---
 rtl/pwm_ramp_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_pwm_ramp_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_ctrl.sv
// PWM generator with bus-programmable period/target and a rate-limited duty ramp.
// Optional `PWM_RAMP_IRQ_EN adds a sticky ramp-done flag (CTRL bit2) and the irq port.
`timescale 1ns/1ps

module pwm_ramp_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16,
    parameter int unsigned ADDR_W = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                valid,
    input  logic [ADDR_W-1:0]   address,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   rdata,
    output logic                ready,
    output logic                pwm_output
`ifdef PWM_RAMP_IRQ_EN
    ,
    output logic                irq
`endif
);

    localparam logic [ADDR_W-1:0] A_PERIOD = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] A_TARGET = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_STEP   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] A_CTRL   = ADDR_W'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RAMP = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CNT_W-1:0]  period, target, step_div;
    logic [CNT_W-1:0]  period_act, cnt, div, duty;
    logic [CNT_W-1:0]  period_act_next, cnt_next, div_next, duty_next;
    logic              en;
    logic              accept, wr, rd, ctrl_wr, en_clear_req;
    logic              boundary, busy;
    logic [DATA_W-1:0] rd_val;
    logic              unused_bits;

`ifdef PWM_RAMP_IRQ_EN
    logic done, done_set;
`endif

    function automatic logic [CNT_W-1:0] merge(
        input logic [CNT_W-1:0]    old,
        input logic [DATA_W-1:0]   d,
        input logic [DATA_W/8-1:0] s
    );
        logic [CNT_W-1:0] r;
        r = old;
        for (int unsigned i = 0; i < CNT_W; i++) begin
            if (s[i/8]) r[i] = d[i];
        end
        return r;
    endfunction

    // A request is taken only when no acknowledge is in flight, forcing a gap cycle.
    assign accept       = valid && !ready;
    assign wr           = accept && (|wstrb);
    assign rd           = accept && !(|wstrb);
    assign ctrl_wr      = wr && (address == A_CTRL) && wstrb[0];
    assign en_clear_req = ctrl_wr && !wdata[0];
    assign busy         = (duty != target);
    assign boundary     = (period_act != '0) && (cnt == period_act - 1'b1);
    assign unused_bits  = ^{wdata, wstrb};

    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        div_next        = div;
        duty_next       = duty;
        period_act_next = period_act;
        case (state)
            IDLE: begin
                cnt_next = '0;
                div_next = '0;
                if (en) begin
                    state_next      = RUN;
                    period_act_next = period;
                end
            end
            RUN, RAMP: begin
                if (!en) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    div_next   = '0;
                end else if (period_act == '0) begin
                    cnt_next = '0;
                end else if (!boundary) begin
                    cnt_next = cnt + 1'b1;
                end else begin
                    cnt_next        = '0;
                    period_act_next = period;
                    // A concurrent EN=0 write suppresses the duty step on this boundary.
                    if (!en_clear_req) begin
                        if (duty == target) begin
                            state_next = RUN;
                            div_next   = '0;
                        end else begin
                            state_next = RAMP;
                            if (step_div == '0 || div == step_div) begin
                                div_next = '0;
                                if (step_div == '0)
                                    duty_next = target;
                                else if (target > duty)
                                    duty_next = duty + 1'b1;
                                else
                                    duty_next = duty - 1'b1;
                                if (duty_next == target) state_next = RUN;
                            end else begin
                                div_next = div + 1'b1;
                            end
                        end
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef PWM_RAMP_IRQ_EN
    // Ramp completion: a boundary that lands in RUN either from RAMP or by moving duty.
    assign done_set = (state != IDLE) && boundary && !en_clear_req && (state_next == RUN)
                      && ((state == RAMP) || (duty_next != duty));
    assign irq      = done;
`endif

    always_comb begin
        rd_val = '0;
        case (address)
            A_PERIOD: rd_val[CNT_W-1:0] = period;
            A_TARGET: rd_val[CNT_W-1:0] = target;
            A_STEP:   rd_val[CNT_W-1:0] = step_div;
            A_CTRL: begin
                rd_val[0] = en;
                rd_val[1] = busy;
`ifdef PWM_RAMP_IRQ_EN
                rd_val[2] = done;
`endif
                for (int unsigned i = 0; i < CNT_W; i++) begin
                    if (CNT_W <= 16 && i + 16 < DATA_W) rd_val[i+16] = duty[i];
                end
            end
            default: rd_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            period     <= '0;
            target     <= '0;
            step_div   <= '0;
            en         <= 1'b0;
            period_act <= '0;
            cnt        <= '0;
            div        <= '0;
            duty       <= '0;
            ready      <= 1'b0;
            rdata      <= '0;
            pwm_output <= 1'b0;
`ifdef PWM_RAMP_IRQ_EN
            done       <= 1'b0;
`endif
        end else begin
            ready      <= accept;
            rdata      <= rd ? rd_val : '0;
            period_act <= period_act_next;
            cnt        <= cnt_next;
            div        <= div_next;
            duty       <= duty_next;
            pwm_output <= (state != IDLE) && en && (period_act != '0) && (cnt < duty);
            if (wr) begin
                case (address)
                    A_PERIOD: period   <= merge(period, wdata, wstrb);
                    A_TARGET: target   <= merge(target, wdata, wstrb);
                    A_STEP:   step_div <= merge(step_div, wdata, wstrb);
                    default: ;
                endcase
            end
            if (ctrl_wr) en <= wdata[0];
`ifdef PWM_RAMP_IRQ_EN
            if (done_set)
                done <= 1'b1;
            else if (ctrl_wr && wdata[2])
                done <= 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: bus reads queue expected data, a monitor checks each ack.
`timescale 1ns/1ps

module tb_pwm_ramp_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid = 1'b0;
    logic [1:0]  address = '0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [31:0] rdata;
    logic        ready;
    logic        pwm_output;
`ifdef PWM_RAMP_IRQ_EN
    logic        irq;
    localparam logic [31:0] DONE_BIT = 32'h4;
`else
    localparam logic [31:0] DONE_BIT = 32'h0;
`endif

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int base = 0;

    typedef struct {
        bit          chk;
        logic [31:0] exp;
        logic [31:0] mask;
        string       name;
    } exp_t;
    exp_t sb[$];

    pwm_ramp_ctrl #(.DATA_W(32), .CNT_W(16), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .valid(valid), .address(address), .wdata(wdata),
        .wstrb(wstrb), .rdata(rdata), .ready(ready), .pwm_output(pwm_output)
`ifdef PWM_RAMP_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every acknowledge consumes one scoreboard entry.
    always @(negedge clk) begin
        if (ready === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_ack: ready=1 required no acknowledge");
            end else begin
                e = sb.pop_front();
                if (e.chk) begin
                    compared++;
                    if ((rdata & e.mask) !== e.exp) begin
                        mismatched++;
                        $display("FAIL %s: rdata=0x%08h required 0x%08h (mask 0x%08h)",
                                 e.name, rdata & e.mask, e.exp, e.mask);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_until(input int c);
        if (cyc > c) check("schedule", cyc, c);
        while (cyc < c) tick(1);
    endtask

    task automatic bus(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s,
                       input bit chk, input logic [31:0] exp, input logic [31:0] mask,
                       input string name);
        exp_t e;
        e.chk = chk; e.exp = exp; e.mask = mask; e.name = name;
        sb.push_back(e);
        valid = 1'b1; address = a; wdata = d; wstrb = s;
        @(posedge clk);
        #1;
        valid = 1'b0; wstrb = '0;
        check({name, "_ack"}, {31'b0, ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus(a, d, 4'hF, 1'b0, '0, '0, "wr");
    endtask

    task automatic wrs(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
        bus(a, d, s, 1'b0, '0, '0, "wrs");
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp, input logic [31:0] mask,
                      input string name);
        bus(a, '0, 4'h0, 1'b1, exp, mask, name);
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (pwm_output) h++;
        end
    endtask

    task automatic count_rises(input int n, output int r);
        logic prev;
        prev = pwm_output;
        r = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
            if (pwm_output && !prev) r++;
            prev = pwm_output;
        end
    endtask

    task automatic wait_rise(output int at);
        logic prev;
        prev = pwm_output;
        at = -1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (pwm_output && !prev) begin
                at = cyc;
                break;
            end
            prev = pwm_output;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int h, r, r1, r2;
        tick(3);
        rst = 1'b0;

        // Reset state
        check("reset_pwm", {31'b0, pwm_output}, 32'd0);
`ifdef PWM_RAMP_IRQ_EN
        check("reset_irq", {31'b0, irq}, 32'd0);
`endif
        for (int a = 0; a < 4; a++) rd(2'(a), 32'h0, '1, "reset_rd");

        // Byte strobes and unused bits
        wrs(2'd0, 32'h1234_5678, 4'b0001);
        rd(2'd0, 32'h0000_0078, '1, "strobe_b0");
        wrs(2'd0, 32'hAAAA_BB00, 4'b0010);
        rd(2'd0, 32'h0000_BB78, '1, "strobe_b1");
        wr(2'd2, 32'hFFFF_FFFF);
        rd(2'd2, 32'h0000_FFFF, '1, "unused_zero");
        wrs(2'd3, 32'hFFFF_FFFF, 4'b1110);
        rd(2'd3, 32'h0, '1, "ctrl_strobe_off");

        // Back-to-back valid: acknowledge every other cycle
        begin
            exp_t e;
            e.chk = 1'b1; e.exp = 32'h0000_FFFF; e.mask = '1; e.name = "b2b_rd";
            sb.push_back(e);
            sb.push_back(e);
            valid = 1'b1; address = 2'd2; wstrb = 4'h0;
            for (int i = 0; i < 4; i++) begin
                @(posedge clk);
                #1;
                check("b2b_ready", {31'b0, ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
            end
            valid = 1'b0;
            tick(1);
        end

        // Steady PWM: period 10, duty 3 via immediate jump
        wr(2'd0, 32'd10);
        wr(2'd1, 32'd0);
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd3);
        wr(2'd3, 32'd1);
        count_high(10, h);
        check("first_period_low", h, 0);
        count_high(10, h);
        check("duty3_high", h, 3);
        count_rises(30, r);
        check("period10_rises", r, 3);
        rd(2'd3, 32'h0003_0001, ~32'h4, "ctrl_run");

        // Ramp 0 -> 4, period 8, one step per 3 periods
        wr(2'd1, 32'd0);
        tick(12);
        wr(2'd3, 32'd0);
        wr(2'd0, 32'd8);
        wr(2'd2, 32'd2);
        wr(2'd1, 32'd4);
        rd(2'd3, 32'h0000_0002, ~32'h4, "idle_busy");
        wr(2'd3, 32'd5);
        base = cyc;
        wait_until(base + 20);
        rd(2'd3, 32'h0000_0003, '1, "ramp_d0");
        wait_until(base + 30);
        rd(2'd3, 32'h0001_0003, '1, "ramp_d1");
        wait_until(base + 50);
        rd(2'd3, 32'h0002_0003, '1, "ramp_d2");
        count_high(8, h);
        check("duty2_high", h, 2);
        wait_until(base + 90);
        rd(2'd3, 32'h0003_0003, '1, "ramp_d3");
`ifdef PWM_RAMP_IRQ_EN
        wait_until(base + 95);
        check("irq_before_done", {31'b0, irq}, 32'd0);
        wait_until(base + 96);
        check("irq_on_done", {31'b0, irq}, 32'd1);
`endif
        wait_until(base + 100);
        rd(2'd3, 32'h0004_0001 | DONE_BIT, '1, "ramp_d4");
        wr(2'd3, 32'd5);
`ifdef PWM_RAMP_IRQ_EN
        check("irq_cleared", {31'b0, irq}, 32'd0);
`endif
        rd(2'd3, 32'h0004_0001, '1, "ctrl_cleared");

        // Mid-ramp redirect: ramp toward 9, lower target to 5 at duty 6
        wait_until(base + 108);
        wr(2'd1, 32'd9);
        wait_until(base + 160);
        wr(2'd1, 32'd5);
        wait_until(base + 170);
        rd(2'd3, 32'h0006_0003, '1, "redirect_d6");
        wait_until(base + 180);
        rd(2'd3, 32'h0005_0001 | DONE_BIT, '1, "redirect_d5");

        // Mid-period PERIOD write completes the old period first
        wait_until(base + 184);
        wr(2'd0, 32'd6);
        wait_rise(r1);
        check("old_period_rise", r1 - base, 193);
        wait_rise(r2);
        check("new_period_rise", r2 - base, 199);

        // Duty above period: constant high
        wr(2'd2, 32'd0);
        wr(2'd1, 32'd8);
        tick(20);
        count_high(12, h);
        check("duty_ge_period_high", h, 12);
        rd(2'd3, 32'h0008_0001, ~32'h4, "ctrl_d8");

        // EN off during high output
        check("pwm_high_before_off", {31'b0, pwm_output}, 32'd1);
        wr(2'd3, 32'd0);
        check("en_off_pwm", {31'b0, pwm_output}, 32'd0);
        rd(2'd3, 32'h0008_0000, ~32'h4, "ctrl_off");

        // PERIOD=0 keeps output low
        wr(2'd0, 32'd0);
        wr(2'd3, 32'd1);
        count_high(20, h);
        check("period0_low", h, 0);
        rd(2'd0, 32'h0, '1, "period0_rd");

        // Reset during a ramp
        wr(2'd3, 32'd0);
        wr(2'd0, 32'd4);
        wr(2'd2, 32'd1);
        wr(2'd1, 32'd2);
        wr(2'd3, 32'd5);
        tick(12);
        rd(2'd3, 32'h3, 32'h3, "ramp_busy");
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_pwm", {31'b0, pwm_output}, 32'd0);
`ifdef PWM_RAMP_IRQ_EN
        check("rst_irq", {31'b0, irq}, 32'd0);
`endif
        for (int a = 0; a < 4; a++) rd(2'(a), 32'h0, '1, "rst_rd");

        tick(3);
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
